// File: rtl/rgb_sequencer_pkg.sv
// Shared definitions for the RGB colour sequencer: play modes and channel count.
package rgb_sequencer_pkg;

    // Play modes, encoded as the 2-bit command mode field.
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_FADE  = 2'd3
    } mode_t;

    // Colour channels per pixel, packed {R,G,B} with R in the MSBs.
    localparam int NCH = 3;

endpackage

// File: rtl/rgb_sequencer_if.sv
// Command channel into the sequencer: one valid/ready transfer per pattern change.
interface rgb_sequencer_if
    import rgb_sequencer_pkg::*;
#(
    parameter int nbpc  = 8,
    parameter int per_w = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    mode_t                 cmd_mode;
    logic [NCH*nbpc-1:0]   cmd_color_a;
    logic [NCH*nbpc-1:0]   cmd_color_b;
    logic [per_w-1:0]      cmd_period;

    modport master (
        output cmd_valid, cmd_mode, cmd_color_a, cmd_color_b, cmd_period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_color_a, cmd_color_b, cmd_period,
        output cmd_ready
    );
endinterface

// File: rtl/rgb_tick_gen.sv
// Run-time programmable step prescaler: tick every period+1 clocks, restartable by clr.
module rgb_tick_gen #(
    parameter int per_w = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [per_w-1:0] period,
    output logic             tick
);
    logic [per_w-1:0] r_cnt;

    assign tick = (r_cnt == period);

    // Count 0..period and wrap; clr restarts so a new command gets a full first step.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + per_w'(1);
        end
    end
endmodule

// File: rtl/rgb_sequencer.sv
// Colour pattern engine: latches one command and plays OFF/SOLID/BLINK/FADE into the PWM stage.
module rgb_sequencer
    import rgb_sequencer_pkg::*;
#(
    parameter int nbpc  = 8,
    parameter int per_w = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    rgb_sequencer_if.slave      cmd,
    output logic [NCH*nbpc-1:0] color,
    output logic                en,
    output logic                cycle_done
);
    localparam int CW = NCH * nbpc;

    mode_t             r_mode,   w_mode;
    logic [CW-1:0]     r_a,      w_a;
    logic [CW-1:0]     r_b,      w_b;
    logic [CW-1:0]     r_color,  w_color;
    logic [per_w-1:0]  r_period, w_period;
    logic              r_phase,  w_phase;
    logic              r_en,     w_en;
    logic              r_done,   w_done;
    logic              r_ready;

    logic              w_accept;
    logic              w_tick;
    logic [CW-1:0]     w_tgt;
    logic [CW-1:0]     w_step;
    logic [NCH-1:0]    w_eq;

    assign w_accept      = cmd.cmd_valid & r_ready;
    assign cmd.cmd_ready = r_ready;
    assign color         = r_color;
    assign en            = r_en;
    assign cycle_done    = r_done;

    rgb_tick_gen #(.per_w(per_w)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_accept),
        .period (r_period),
        .tick   (w_tick)
    );

    // phase=0 heads toward B, phase=1 heads back toward A.
    assign w_tgt = r_phase ? r_a : r_b;

    // One stepper per channel: move one LSB toward the target, never past it.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [nbpc-1:0] w_c, w_t;
        assign w_c = r_color[g*nbpc +: nbpc];
        assign w_t = w_tgt[g*nbpc +: nbpc];
        assign w_eq[g] = (w_c == w_t);
        assign w_step[g*nbpc +: nbpc] = (w_c < w_t) ? w_c + nbpc'(1) :
                                        (w_c > w_t) ? w_c - nbpc'(1) : w_c;
    end

    // State register; reset wins over any in-flight command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode   <= MODE_OFF;
            r_a      <= '0;
            r_b      <= '0;
            r_color  <= '0;
            r_period <= '0;
            r_phase  <= 1'b0;
            r_en     <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_mode   <= w_mode;
            r_a      <= w_a;
            r_b      <= w_b;
            r_color  <= w_color;
            r_period <= w_period;
            r_phase  <= w_phase;
            r_en     <= w_en;
            r_done   <= w_done;
            r_ready  <= 1'b1;
        end
    end

    // Next state: a command restarts the pattern from A; otherwise ticks advance it.
    always_comb begin
        w_mode   = r_mode;
        w_a      = r_a;
        w_b      = r_b;
        w_period = r_period;
        w_phase  = r_phase;
        w_color  = r_color;
        w_en     = r_en;
        w_done   = 1'b0;
        if (w_accept) begin
            w_mode   = cmd.cmd_mode;
            w_a      = cmd.cmd_color_a;
            w_b      = cmd.cmd_color_b;
            w_period = cmd.cmd_period;
            w_phase  = 1'b0;
            w_en     = (cmd.cmd_mode != MODE_OFF);
            w_color  = (cmd.cmd_mode != MODE_OFF) ? cmd.cmd_color_a : '0;
        end else if (w_tick) begin
            unique case (r_mode)
                MODE_BLINK: begin
                    w_phase = ~r_phase;
                    w_color = r_phase ? r_a : r_b;
                    w_done  = 1'b1;
                end
                MODE_FADE: begin
                    if (&w_eq) begin
                        // Endpoint reached: hold this tick and turn around.
                        w_phase = ~r_phase;
                        w_done  = 1'b1;
                    end else begin
                        w_color = w_step;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rgb_sequencer.sv
// Randomised + directed bench for rgb_sequencer with a scoreboard fed by a behavioural model.
module tb_rgb_sequencer;
    import rgb_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] color;
    logic        en, cycle_done;

    rgb_sequencer_if #(.nbpc(8), .per_w(16)) cif ();

    rgb_sequencer #(.nbpc(8), .per_w(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cif),
        .color      (color),
        .en         (en),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] color;
        logic        en;
        logic        done;
        logic        ready;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: colours as integer channels, time as clocks since command.
    int m_mode = 0;
    int m_a[3], m_b[3], m_c[3];
    int m_per = 0;
    int m_since = 0;
    bit m_back = 0;
    bit m_ready = 0, m_en = 0, m_done = 0;

    function automatic logic [23:0] pack3(input int c[3]);
        logic [7:0] r, g, b;
        r = 8'(c[0]); g = 8'(c[1]); b = 8'(c[2]);
        return {r, g, b};
    endfunction

    task automatic unpack3(input logic [23:0] v, output int c[3]);
        c[0] = int'(v[23:16]);
        c[1] = int'(v[15:8]);
        c[2] = int'(v[7:0]);
    endtask

    function automatic bit tick_next();
        return (m_ready && (m_since % (m_per + 1)) == m_per);
    endfunction

    task automatic model(input bit r, input bit v, input int mode,
                         input logic [23:0] a, input logic [23:0] b, input int per);
        bit acc, tick, same;
        int tgt[3];
        if (!r) begin
            m_mode = 0; m_c = '{0, 0, 0}; m_en = 0; m_done = 0;
            m_ready = 0; m_since = 0; m_back = 0; m_per = 0;
        end else begin
            acc = v && m_ready;
            m_ready = 1;
            m_done = 0;
            if (acc) begin
                m_mode = mode;
                unpack3(a, m_a);
                unpack3(b, m_b);
                m_per = per;
                m_since = 0;
                m_back = 0;
                m_en = (mode != 0);
                if (mode == 0) m_c = '{0, 0, 0};
                else m_c = m_a;
            end else begin
                tick = ((m_since % (m_per + 1)) == m_per);
                m_since++;
                if (tick && m_mode == 2) begin
                    m_back = !m_back;
                    m_c = m_back ? m_b : m_a;
                    m_done = 1;
                end else if (tick && m_mode == 3) begin
                    tgt = m_back ? m_a : m_b;
                    same = 1;
                    for (int i = 0; i < 3; i++) if (m_c[i] != tgt[i]) same = 0;
                    if (same) begin
                        m_back = !m_back;
                        m_done = 1;
                    end else begin
                        for (int i = 0; i < 3; i++) begin
                            if (m_c[i] < tgt[i]) m_c[i]++;
                            else if (m_c[i] > tgt[i]) m_c[i]--;
                        end
                    end
                end
            end
        end
    endtask

    // One clock: drive inputs, predict post-edge outputs, advance past the edge.
    task automatic cyc(input bit r, input bit v, input int mode,
                       input logic [23:0] a, input logic [23:0] b, input int per);
        exp_t e;
        logic [1:0] mb;
        mb = 2'(mode);
        rst_n           = r;
        cif.cmd_valid   = v;
        cif.cmd_mode    = mode_t'(mb);
        cif.cmd_color_a = a;
        cif.cmd_color_b = b;
        cif.cmd_period  = 16'(per);
        model(r, v, mode, a, b, per);
        e.color = pack3(m_c);
        e.en    = m_en;
        e.done  = m_done;
        e.ready = m_ready;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b1, 1'b0, int'($urandom_range(0, 3)), 24'($urandom()), 24'($urandom()),
                int'($urandom_range(0, 9)));
    endtask

    task automatic issue(input int mode, input logic [23:0] a, input logic [23:0] b, input int per);
        cyc(1'b1, 1'b1, mode, a, b, per);
    endtask

    // Monitor: every clock presents a result; compare it against the oldest prediction.
    always @(negedge clk) begin : mon
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if ({color, en, cycle_done, cif.cmd_ready} !== {e.color, e.en, e.done, e.ready}) begin
                miscompares++;
                $display("FAIL out@%0t: got color=%h en=%b done=%b ready=%b, want color=%h en=%b done=%b ready=%b",
                         $time, color, en, cycle_done, cif.cmd_ready, e.color, e.en, e.done, e.ready);
            end
        end
    end

    initial begin
        // Reset held with a command pending; ready appears one clock after release.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1, 24'h123456, 24'h654321, 2);
        cyc(1'b1, 1'b0, 1, 24'h0, 24'h0, 0);
        idle(2);

        // SOLID holds indefinitely.
        issue(1, 24'hFF8000, 24'h00FFFF, 0);
        idle(1000);

        // BLINK every 4 clocks, then OFF.
        issue(2, 24'hFF0000, 24'h0000FF, 3);
        idle(20);
        issue(0, 24'hABCDEF, 24'h123456, 1);
        idle(5);

        // FADE 000000 <-> 030201 at full rate, through both endpoints.
        issue(3, 24'h000000, 24'h030201, 0);
        idle(16);

        // New BLINK accepted exactly on a tick clock: tick is discarded.
        issue(2, 24'h00FF00, 24'hFF00FF, 3);
        for (int i = 0; i < 20; i++) begin
            if (tick_next()) break;
            idle(1);
        end
        issue(2, 24'h112233, 24'h445566, 3);
        idle(10);

        // FADE with A==B: constant colour, endpoint pulse every tick.
        issue(3, 24'h405060, 24'h405060, 2);
        idle(12);

        // One-clock reset mid-FADE, then nothing until a new command.
        issue(3, 24'h10F020, 24'h201030, 1);
        idle(9);
        cyc(1'b0, 1'b1, 3, 24'hFFFFFF, 24'h000000, 0);
        idle(20);
        issue(1, 24'h0A0B0C, 24'h0, 0);
        idle(3);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 24) == 0),
                int'($urandom_range(0, 3)), 24'($urandom()), 24'($urandom()),
                int'($urandom_range(0, 6)));
        end
        // Near-endpoint random fades so turnarounds happen often.
        for (int k = 0; k < 20; k++) begin
            logic [23:0] a;
            a = 24'($urandom());
            issue(3, a, a ^ 24'($urandom_range(0, 7) * 24'h010101 & 24'h070707), int'($urandom_range(0, 2)));
            idle(int'($urandom_range(10, 40)));
        end

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
